ll_telemetry_tx: RTL and testbench
==================================

Name: ll_telemetry_tx

Overview:
- Periodically serializes the lunar lander state as a fixed 28-byte ASCII frame onto the board's byte-wide UART transmit port (txdata/txclk/txready).
- Outbound counterpart to the keypad input path: it carries game state off the board.
- Sits beside the display block; it reads the same alt/vel/fuel/thrust BCD registers and land/crash flags.

Parameters:
PERIOD, 8'd100, frame interval in hz100 cycles; 0 disables periodic frames, leaving event frames only
PW, 8, width of the interval counter

Ports:
hz100  input  1  system clock
reset  input  1  synchronous, active-low reset
alt  input  16  altitude, 4-digit BCD
vel  input  16  velocity, 4-digit BCD, ten's complement (negative when vel[15:12]==9)
fuel  input  16  fuel, 4-digit BCD
thrust  input  16  thrust, 4-digit BCD
land  input  1  landed flag
crash  input  1  crashed flag
txready  input  1  UART can accept a byte
txdata  output  8  byte to transmit
txclk  output  1  one-cycle strobe, byte accepted on this cycle
busy  output  1  high from LOAD until the last byte's GAP completes
frame_cnt  output  8  completed frames, wraps 255->0

Behaviour:
- Reset: all sampled on hz100 while reset==0. txdata=0, txclk=0, busy=0, frame_cnt=0, timer=0, pending=0, state=IDLE. Asserting reset mid-frame aborts the frame immediately; no further bytes are sent.
- Timer: counts 0..PERIOD-1. A tick occurs when timer==PERIOD-1, then timer wraps to 0. The first tick occurs PERIOD cycles after reset release.
- Event: a registered rising edge of land or of crash generates a request.
- Request sources: tick or event. Simultaneous sources give one request.
- Pending: a request arriving outside IDLE sets pending. Multiple requests collapse into one; pending clears on entry to LOAD.
- FSM states: IDLE, LOAD, SEND, GAP.
  - IDLE: on (request or pending), go to LOAD next cycle.
  - LOAD: snapshot alt, vel, fuel, thrust, land, crash. Compute the velocity sign and magnitude; magnitude = BCD 0000 - vel when negative, else vel. Set idx=0 and go to SEND. busy=1.
  - SEND: when txready==1, on the next cycle txclk=1 and txdata=byte[idx], then go to GAP. When txready==0, hold with txclk=0.
  - GAP: txclk=0. If idx==27, increment frame_cnt and go to IDLE (busy=0 that cycle). Otherwise increment idx and go to SEND.
- Byte rate: at most one byte every 2 cycles; a frame takes at least 56 cycles. No txclk pulses occur back-to-back.
- txdata holds the last byte sent until the next strobe.
- Frame layout (idx 0..27): 'A' a3 a2 a1 a0 ' ' 'V' s v3 v2 v1 v0 ' ' 'F' f3 f2 f1 f0 ' ' 'T' t3 t2 t1 t0 ' ' S CR(0x0D) LF(0x0A).
- Digit encoding: nibble 0-9 maps to 0x30+nibble; nibble A-F maps to '?' (0x3F). Leading zeros are always sent.
- Velocity sign s: '-' (0x2D) when the snapshot vel[15:12]==9, else '+' (0x2B). vel==0 gives '+'.
- Status S: 'X' (0x58) if crash, else 'L' (0x4C) if land, else 'R' (0x52). crash wins if both flags are set.
- Inputs that change after LOAD do not affect the frame in flight.
- If PERIOD is shorter than the frame time, frames run back to back: one LOAD at most 2 cycles after the previous frame's final GAP.

Test Plan:
- Periodic frame: release reset with alt=4500, vel=0000, fuel=0800, thrust=0005, land=crash=0, txready=1. The frame starts at cycle 100 and the byte stream is "A4500 V+0000 F0800 T0005 R\r\n". There are exactly 28 txclk pulses, each 2 cycles apart; then frame_cnt=1 and busy=0.
- Negative velocity: vel=9950 and crash=1 (rising edge). An event frame is sent immediately, with the V field "-0050" and status 'X'. Setting land=crash=1 also gives 'X'.
- Backpressure: hold txready=0 for 10 cycles during byte 5. There is no txclk while txready is low. The byte sent when txready returns is ' ', with no byte skipped or duplicated.
- Collision: assert a land rising edge and a timer tick in the same cycle, plus another tick mid-frame. Exactly two frames are sent, back to back, and frame_cnt increments by 2.
- Snapshot integrity: change alt to 1234 at byte 3. The current frame keeps "4500"; the next frame shows "1234". An invalid nibble (alt=4A00) is sent as "4?00".
- Reset mid-frame: drive reset=0 at byte 10 for 1 cycle. The next cycle has txclk=0, txdata=0, busy=0 and frame_cnt=0. No bytes follow until PERIOD cycles after reset release.

Source files
------------

// File: rtl/ll_telemetry_tx.sv
// Lunar lander telemetry serializer: snapshots the BCD game state and streams a
// fixed 28-byte ASCII frame onto the byte-wide UART port, periodically or on land/crash.
module ll_telemetry_tx #(
    parameter int              PW     = 8,
    parameter logic [PW-1:0]   PERIOD = 8'd100
) (
    input  logic        hz100,
    input  logic        reset,
    input  logic [15:0] alt,
    input  logic [15:0] vel,
    input  logic [15:0] fuel,
    input  logic [15:0] thrust,
    input  logic        land,
    input  logic        crash,
    input  logic        txready,
    output logic [7:0]  txdata,
    output logic        txclk,
    output logic        busy,
    output logic [7:0]  frame_cnt
);

    typedef enum logic [1:0] {IDLE, LOAD, SEND, GAP} state_t;

    typedef struct packed {
        logic [15:0] alt;
        logic [15:0] vmag;
        logic [15:0] fuel;
        logic [15:0] thrust;
        logic        neg;
        logic        land;
        logic        crash;
    } snap_t;

    localparam logic [4:0] LAST_IDX = 5'd27;

    state_t        state, state_nx;
    snap_t         snap;
    logic [PW-1:0] timer;
    logic [4:0]    idx;
    logic          pending, land_q, crash_q;
    logic          tick, event_req, req;
    logic [7:0]    byte_sel;

    function automatic logic [7:0] digit(input logic [3:0] n);
        return (n <= 4'd9) ? (8'h30 + {4'h0, n}) : 8'h3F;
    endfunction

    // Ten's complement magnitude (0000 - v) by digit-serial BCD subtraction.
    function automatic logic [15:0] bcd_neg(input logic [15:0] v);
        logic [15:0] r;
        logic        b;
        logic [4:0]  d;
        r = '0;
        b = 1'b0;
        for (int i = 0; i < 4; i++) begin
            d = 5'd0 - {1'b0, v[4*i +: 4]} - {4'd0, b};
            b = d[4];
            r[4*i +: 4] = b ? (d[3:0] + 4'd10) : d[3:0];
        end
        return r;
    endfunction

    assign tick      = (PERIOD != '0) && (timer == PERIOD - PW'(1));
    assign event_req = (land & ~land_q) | (crash & ~crash_q);
    assign req       = tick | event_req;
    assign busy      = (state != IDLE);

    // Edge detectors follow the inputs through reset so a flag already high
    // at release does not fire a spurious event frame.
    always_ff @(posedge hz100) begin
        land_q  <= land;
        crash_q <= crash;
    end

    always_ff @(posedge hz100) begin
        if (!reset)
            timer <= '0;
        else if (tick || PERIOD == '0)
            timer <= '0;
        else
            timer <= timer + PW'(1);
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (req || pending) state_nx = LOAD;
            LOAD: state_nx = SEND;
            SEND: if (txready) state_nx = GAP;
            GAP:  state_nx = (idx == LAST_IDX) ? IDLE : SEND;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        byte_sel = 8'h00;
        case (idx)
            5'd0:  byte_sel = 8'h41;
            5'd1:  byte_sel = digit(snap.alt[15:12]);
            5'd2:  byte_sel = digit(snap.alt[11:8]);
            5'd3:  byte_sel = digit(snap.alt[7:4]);
            5'd4:  byte_sel = digit(snap.alt[3:0]);
            5'd6:  byte_sel = 8'h56;
            5'd7:  byte_sel = snap.neg ? 8'h2D : 8'h2B;
            5'd8:  byte_sel = digit(snap.vmag[15:12]);
            5'd9:  byte_sel = digit(snap.vmag[11:8]);
            5'd10: byte_sel = digit(snap.vmag[7:4]);
            5'd11: byte_sel = digit(snap.vmag[3:0]);
            5'd13: byte_sel = 8'h46;
            5'd14: byte_sel = digit(snap.fuel[15:12]);
            5'd15: byte_sel = digit(snap.fuel[11:8]);
            5'd16: byte_sel = digit(snap.fuel[7:4]);
            5'd17: byte_sel = digit(snap.fuel[3:0]);
            5'd19: byte_sel = 8'h54;
            5'd20: byte_sel = digit(snap.thrust[15:12]);
            5'd21: byte_sel = digit(snap.thrust[11:8]);
            5'd22: byte_sel = digit(snap.thrust[7:4]);
            5'd23: byte_sel = digit(snap.thrust[3:0]);
            5'd5, 5'd12, 5'd18, 5'd24: byte_sel = 8'h20;
            5'd25: byte_sel = snap.crash ? 8'h58 : (snap.land ? 8'h4C : 8'h52);
            5'd26: byte_sel = 8'h0D;
            5'd27: byte_sel = 8'h0A;
            default: byte_sel = 8'h00;
        endcase
    end

    always_ff @(posedge hz100) begin
        if (!reset) begin
            state     <= IDLE;
            pending   <= 1'b0;
            idx       <= '0;
            txdata    <= '0;
            txclk     <= 1'b0;
            frame_cnt <= '0;
            snap      <= '0;
        end else begin
            state <= state_nx;
            if (state_nx == LOAD)
                pending <= 1'b0;
            else if (req && state != IDLE)
                pending <= 1'b1;
            txclk <= (state == SEND) && txready;
            if (state == SEND && txready)
                txdata <= byte_sel;
            case (state)
                LOAD: begin
                    snap.alt    <= alt;
                    snap.vmag   <= (vel[15:12] == 4'd9) ? bcd_neg(vel) : vel;
                    snap.fuel   <= fuel;
                    snap.thrust <= thrust;
                    snap.neg    <= (vel[15:12] == 4'd9);
                    snap.land   <= land;
                    snap.crash  <= crash;
                    idx         <= '0;
                end
                GAP: begin
                    if (idx == LAST_IDX)
                        frame_cnt <= frame_cnt + 8'd1;
                    else
                        idx <= idx + 5'd1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ll_telemetry_tx.sv
// Directed bench for ll_telemetry_tx: expected frames are queued as stimulus is
// applied and popped byte-by-byte on every txclk strobe.
module tb_ll_telemetry_tx;

    logic        hz100 = 1'b0;
    logic        reset;
    logic [15:0] alt, vel, fuel, thrust;
    logic        land, crash, txready;
    logic [7:0]  txdata;
    logic        txclk;
    logic        busy;
    logic [7:0]  frame_cnt;

    int          n_tests = 0;
    int          n_fail  = 0;
    int          n_pulse = 0;
    int          cyc     = 0;
    logic        prev_tx = 1'b0;
    logic [7:0]  exp_q[$];
    int          pulse_cyc[$];

    ll_telemetry_tx dut (
        .hz100(hz100), .reset(reset), .alt(alt), .vel(vel), .fuel(fuel),
        .thrust(thrust), .land(land), .crash(crash), .txready(txready),
        .txdata(txdata), .txclk(txclk), .busy(busy), .frame_cnt(frame_cnt)
    );

    always #5 hz100 = ~hz100;
    always @(posedge hz100) cyc++;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_tests++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    // Byte monitor / scoreboard
    always @(negedge hz100) begin
        if (txclk) begin
            n_pulse++;
            pulse_cyc.push_back(cyc);
            chk("no_back_to_back", {31'b0, prev_tx}, 32'd0);
            if (exp_q.size() != 0)
                chk($sformatf("byte_%0d", n_pulse), {24'b0, txdata}, {24'b0, exp_q.pop_front()});
            else begin
                n_tests++;
                n_fail++;
                $error("FAIL extra_byte: observed %0h expected none", txdata);
            end
        end
        prev_tx = txclk;
    end

    function automatic logic [7:0] dg(input logic [3:0] n);
        return (n < 4'd10) ? (8'h30 + {4'h0, n}) : 8'h3F;
    endfunction

    function automatic int bcd2int(input logic [15:0] v);
        return 1000 * int'(v[15:12]) + 100 * int'(v[11:8]) + 10 * int'(v[7:4]) + int'(v[3:0]);
    endfunction

    task automatic push4(input logic [15:0] v);
        for (int i = 3; i >= 0; i--) exp_q.push_back(dg(v[4*i +: 4]));
    endtask

    task automatic push_frame(input logic [15:0] a, v, f, t, input logic l, c);
        logic [15:0] m;
        int          n;
        logic        neg;
        neg = (v[15:12] == 4'd9);
        m   = v;
        if (neg) begin
            n = (10000 - bcd2int(v)) % 10000;
            m = {4'(n / 1000), 4'((n / 100) % 10), 4'((n / 10) % 10), 4'(n % 10)};
        end
        exp_q.push_back(8'h41); push4(a); exp_q.push_back(8'h20);
        exp_q.push_back(8'h56); exp_q.push_back(neg ? 8'h2D : 8'h2B); push4(m); exp_q.push_back(8'h20);
        exp_q.push_back(8'h46); push4(f); exp_q.push_back(8'h20);
        exp_q.push_back(8'h54); push4(t); exp_q.push_back(8'h20);
        exp_q.push_back(c ? 8'h58 : (l ? 8'h4C : 8'h52));
        exp_q.push_back(8'h0D); exp_q.push_back(8'h0A);
    endtask

    task automatic step();
        @(negedge hz100);
        #1;
    endtask

    task automatic rst_cycle();
        step(); reset = 1'b0;
        step(); step(); reset = 1'b1;
    endtask

    task automatic wait_cnt(input logic [7:0] tgt, input int budget, input string tag);
        for (int i = 0; i < budget && frame_cnt !== tgt; i++) step();
        chk(tag, {24'b0, frame_cnt}, {24'b0, tgt});
    endtask

    task automatic wait_pulses(input int tgt, input int budget, input string tag);
        for (int i = 0; i < budget && n_pulse < tgt; i++) step();
        chk(tag, n_pulse, tgt);
    endtask

    initial begin
        int base, p, bad;
        reset = 1'b0; txready = 1'b1; land = 1'b0; crash = 1'b0;
        alt = 16'h4500; vel = 16'h0000; fuel = 16'h0800; thrust = 16'h0005;
        repeat (3) step();
        chk("rst_txclk", {31'b0, txclk}, 32'd0);
        chk("rst_txdata", {24'b0, txdata}, 32'd0);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_frame_cnt", {24'b0, frame_cnt}, 32'd0);

        // Periodic frame from the first timer tick
        push_frame(16'h4500, 16'h0000, 16'h0800, 16'h0005, 1'b0, 1'b0);
        reset = 1'b1;
        repeat (99) step();
        chk("no_early_start", {31'b0, busy}, 32'd0);
        step();
        chk("start_at_100", {31'b0, busy}, 32'd1);
        wait_cnt(8'd1, 200, "periodic_done");
        chk("periodic_busy_low", {31'b0, busy}, 32'd0);
        chk("periodic_28_bytes", n_pulse, 32'd28);
        bad = 0;
        for (int i = 1; i < 28; i++) if (pulse_cyc[i] - pulse_cyc[i-1] != 2) bad++;
        chk("periodic_spacing", bad, 32'd0);

        // Crash event with negative velocity
        vel = 16'h9950;
        rst_cycle();
        step(); step();
        push_frame(16'h4500, 16'h9950, 16'h0800, 16'h0005, 1'b0, 1'b1);
        crash = 1'b1;
        wait_cnt(8'd1, 150, "crash_done");
        chk("crash_busy_low", {31'b0, busy}, 32'd0);

        // Both flags rising together: crash wins
        crash = 1'b0;
        rst_cycle();
        step(); step();
        push_frame(16'h4500, 16'h9950, 16'h0800, 16'h0005, 1'b1, 1'b1);
        land = 1'b1; crash = 1'b1;
        wait_cnt(8'd1, 150, "both_done");

        // Backpressure on byte 5
        land = 1'b0; crash = 1'b0; vel = 16'h0000;
        rst_cycle();
        step(); step();
        push_frame(16'h4500, 16'h0000, 16'h0800, 16'h0005, 1'b1, 1'b0);
        base = n_pulse;
        land = 1'b1;
        wait_pulses(base + 5, 100, "bp_reach_byte5");
        txready = 1'b0;
        p = n_pulse;
        repeat (10) step();
        chk("bp_no_strobe", n_pulse, p);
        txready = 1'b1;
        wait_cnt(8'd1, 150, "bp_done");
        chk("bp_byte_count", n_pulse, base + 28);

        // Land edge coincident with a tick, second tick during a stalled frame
        land = 1'b0;
        rst_cycle();
        repeat (99) step();
        push_frame(16'h4500, 16'h0000, 16'h0800, 16'h0005, 1'b1, 1'b0);
        push_frame(16'h4500, 16'h0000, 16'h0800, 16'h0005, 1'b1, 1'b0);
        base = n_pulse;
        land = 1'b1;
        repeat (31) step();
        txready = 1'b0;
        repeat (70) step();
        txready = 1'b1;
        wait_cnt(8'd1, 200, "coll_first_done");
        step();
        chk("coll_back_to_back_load", {31'b0, busy}, 32'd1);
        wait_cnt(8'd2, 200, "coll_second_done");
        repeat (5) step();
        chk("coll_only_two", n_pulse, base + 56);
        chk("coll_idle", {31'b0, busy}, 32'd0);

        // Snapshot integrity, then new value, then invalid nibble
        land = 1'b0;
        rst_cycle();
        step(); step();
        push_frame(16'h4500, 16'h0000, 16'h0800, 16'h0005, 1'b1, 1'b0);
        base = n_pulse;
        land = 1'b1;
        wait_pulses(base + 3, 100, "snap_reach_byte3");
        alt = 16'h1234;
        wait_cnt(8'd1, 150, "snap_first_done");
        land = 1'b0;
        rst_cycle();
        step(); step();
        push_frame(16'h1234, 16'h0000, 16'h0800, 16'h0005, 1'b1, 1'b0);
        land = 1'b1;
        wait_cnt(8'd1, 150, "snap_second_done");
        land = 1'b0; alt = 16'h4A00;
        rst_cycle();
        step(); step();
        push_frame(16'h4A00, 16'h0000, 16'h0800, 16'h0005, 1'b1, 1'b0);
        land = 1'b1;
        wait_cnt(8'd1, 150, "invalid_nibble_done");

        // Reset mid-frame at byte 10
        land = 1'b0; alt = 16'h4500;
        rst_cycle();
        step(); step();
        push_frame(16'h4500, 16'h0000, 16'h0800, 16'h0005, 1'b1, 1'b0);
        base = n_pulse;
        land = 1'b1;
        wait_pulses(base + 10, 100, "abort_reach_byte10");
        reset = 1'b0;
        exp_q.delete();
        step();
        chk("abort_txclk", {31'b0, txclk}, 32'd0);
        chk("abort_txdata", {24'b0, txdata}, 32'd0);
        chk("abort_busy", {31'b0, busy}, 32'd0);
        chk("abort_frame_cnt", {24'b0, frame_cnt}, 32'd0);
        reset = 1'b1;
        p = n_pulse;
        repeat (99) step();
        chk("abort_silent", n_pulse, p);
        chk("abort_idle", {31'b0, busy}, 32'd0);
        push_frame(16'h4500, 16'h0000, 16'h0800, 16'h0005, 1'b1, 1'b0);
        step();
        chk("abort_restart_tick", {31'b0, busy}, 32'd1);
        wait_cnt(8'd1, 200, "abort_restart_done");

        chk("scoreboard_empty", exp_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
